// File: rtl/axis_fifo_pkg.sv
// Shared defaults and storage-entry layout for the AXI4-Stream FIFO.
// Optional occupancy port is enabled with AXIS_FIFO_LEVEL_EN (see axis_fifo_top).
package axis_fifo_pkg;

    localparam int DW_DEF = 16;
    localparam int DD_DEF = 2048;
    localparam int AW_DEF = 12;

    typedef struct packed {
        logic              last;
        logic [DW_DEF-1:0] data;
    } axis_entry_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read, no reset.
module axis_fifo_ram #(
    parameter int DW = 16,
    parameter int DD = 2048,
    parameter int IW = 11
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [DW:0]   wr_data,
    input  logic [IW-1:0] rd_addr,
    output logic [DW:0]   rd_data
);

    logic [DW:0] mem [DD];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo_top.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO carrying {tlast, tdata}.
// Define AXIS_FIFO_LEVEL_EN to expose the occupancy register on output port 'level'.
module axis_fifo_top
    import axis_fifo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int DD = DD_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    output logic [AW-1:0] level
`endif
);

    localparam int IW = (DD > 1) ? $clog2(DD) : 1;
    localparam logic [AW-1:0] LVL_FULL = AW'(DD);
    localparam logic [AW-1:0] PTR_LAST = AW'(DD - 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] level_q;
    logic          push;
    logic          pop;
    logic [DW:0]   rd_word;

    // Explicit compare-and-clear so any depth wraps correctly, not just powers of two.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign s_tready = !rst && (level_q != LVL_FULL);
    assign m_tvalid = (level_q != '0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    axis_fifo_ram #(
        .DW (DW),
        .DD (DD),
        .IW (IW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[IW-1:0]),
        .wr_data ({s_tlast, s_tdata}),
        .rd_addr (rd_ptr[IW-1:0]),
        .rd_data (rd_word)
    );

    // Outputs are zeroed when empty so stale storage never leaks downstream.
    assign m_tdata = m_tvalid ? rd_word[DW-1:0] : '0;
    assign m_tlast = m_tvalid & rd_word[DW];

`ifdef AXIS_FIFO_LEVEL_EN
    assign level = level_q;
`endif

endmodule

// File: tb/tb_axis_fifo_top.sv
// Scoreboard bench for axis_fifo_top: reset, fill/overflow, drain, concurrent push/pop,
// mid-operation reset and random backpressure.
module tb_axis_fifo_top;
    import axis_fifo_pkg::*;

    localparam int DW = 16;
    localparam int DD = 2048;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
`ifdef AXIS_FIFO_LEVEL_EN
    logic [AW-1:0] level;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int max_lvl = 0;
    axis_entry_t sb_q[$];

    axis_fifo_top #(.DW(DW), .DD(DD), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready)
`ifdef AXIS_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, check outputs against the model,
    // cross the rising edge, update the model, and return at the next falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r,
                        input string tag);
        logic        exp_rdy;
        logic        exp_vld;
        axis_entry_t front;
        logic        do_push;
        logic        do_pop;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        #1;
        exp_rdy = (sb_q.size() != DD);
        exp_vld = (sb_q.size() != 0);
        front   = exp_vld ? sb_q[0] : '0;
        check({tag, ".s_tready"}, 32'(s_tready), 32'(exp_rdy));
        check({tag, ".m_tvalid"}, 32'(m_tvalid), 32'(exp_vld));
        check({tag, ".m_tdata"},  32'(m_tdata),  32'(front.data));
        check({tag, ".m_tlast"},  32'(m_tlast),  32'(front.last));
`ifdef AXIS_FIFO_LEVEL_EN
        check({tag, ".level"}, 32'(level), 32'(sb_q.size()));
`endif
        do_push = v && exp_rdy;
        do_pop  = r && exp_vld;
        @(posedge clk);
        if (do_pop) begin
            void'(sb_q.pop_front());
        end
        if (do_push) begin
            sb_q.push_back('{last: l, data: d});
        end
        if (sb_q.size() > max_lvl) max_lvl = sb_q.size();
        @(negedge clk);
    endtask

    initial begin
        // Reset held from time 0 through 30 ns
        #12;
        check("rst.s_tready", 32'(s_tready), 32'd0);
        check("rst.m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst.m_tdata",  32'(m_tdata),  32'd0);
        check("rst.m_tlast",  32'(m_tlast),  32'd0);
        wait ($time >= 30);
        rst = 1'b0;
        #1;
        check("rel.s_tready", 32'(s_tready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < DD + 1; i++) begin
            step(1'b1, DW'(i), (i % 8) == 7, 1'b0, "fill");
        end
        check("fill.depth", 32'(sb_q.size()), 32'(DD));

        for (int i = 0; i < DD; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, "drain");
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, "empty");
        end

        for (int i = 0; i < 5; i++) begin
            step(1'b1, DW'(16'h100 + i), 1'b0, 1'b0, "pre5");
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(16'h200 + i), i == 9, 1'b1, "pp5");
        end
        check("pp5.level", 32'(sb_q.size()), 32'd5);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, "pp5drn");
        end

        for (int i = 0; i < 100; i++) begin
            step(1'b1, DW'(16'h3000 + i), 1'b0, 1'b0, "l100");
        end
        #2;
        rst = 1'b1;
        #1;
        check("mrst.m_tvalid", 32'(m_tvalid), 32'd0);
        check("mrst.s_tready", 32'(s_tready), 32'd0);
        check("mrst.m_tdata",  32'(m_tdata),  32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'hABCD, 1'b1, 1'b0, "mrst.push");
        check("mrst.first_data", 32'(m_tdata), 32'h0000ABCD);
        check("mrst.first_last", 32'(m_tlast), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, "mrst.pop");
        step(1'b0, '0, 1'b0, 1'b1, "mrst.empty");

        max_lvl = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "rand");
        end
        check("rand.maxlvl_ok", 32'(max_lvl <= DD), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
